pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RA_W, 4, register-index width.
- FWD_EN, 1, mode: 1 forwarding with load-use stall only; 0 stall on any RAW hazard.
- MEM_WAIT, 0, extra MEM-stage cycles per load/store (0..15).
- PERF_W, 16, stall counter width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_src1 / id_src2, in, RA_W each, ID source registers.
- id_src1_used / id_src2_used, in, 1 each, source actually read.
- id_dest, in, RA_W, ID destination.
- id_wb_en, in, 1, ID instruction writes back.
- id_mem_r_en, in, 1, ID instruction is a load.
- id_mem_w_en, in, 1, ID instruction is a store.
- branch_taken, in, 1, EXE resolved a taken branch.
- freeze, out, 1, hold PC and IF/ID.
- bubble, out, 1, load NOP into ID/EXE.
- flush, out, 1, squash IF/ID.
- mem_stall, out, 1, hold every pipeline register.
- fwd_sel_a / fwd_sel_b, out, 2 each, EXE operand source: 00 regfile, 01 MEM alu_res, 10 WB value.
- stall_cycles, out, PERF_W, saturating count of freeze cycles.

Function
REQ-003 The block SHALL track three in-flight entries E0 (EXE), E1 (MEM) and E2 (WB), each holding {valid, dest, wb_en, mem_r_en, mem_w_en}.
REQ-004 When mem_stall=0, entries SHALL advance each cycle: E2<=E1, E1<=E0, E0<=ID fields if id_valid&!freeze&!flush, else invalid.
REQ-005 When mem_stall=1, all entries, fwd_sel and the wait counter's target SHALL hold.
REQ-006 Source match SHALL mean srcN_used & Ek.valid & Ek.wb_en & (Ek.dest==srcN).
REQ-007 FWD_EN=0: hazard SHALL be any source match against E0 or E1; E2 is covered by regfile write-before-read.
REQ-008 FWD_EN=1: hazard SHALL be a source match against E0 with E0.mem_r_en=1 (load-use).
REQ-009 freeze and bubble SHALL equal hazard & id_valid & !branch_taken & !mem_stall, combinationally.
REQ-010 flush SHALL equal branch_taken & !mem_stall; E0 next SHALL be invalid.
REQ-011 Priority SHALL be mem_stall > flush > hazard.
REQ-012 FWD_EN=1: on advance without bubble or flush, fwd_sel_x SHALL register 01 if the source matches E0, else 10 if it matches E1, else 00. E0 wins over E1.
REQ-013 FWD_EN=0, or when an invalid entry enters E0, fwd_sel_a and fwd_sel_b SHALL register 00.
REQ-014 When E0 advances into E1 with mem_r_en|mem_w_en, a 4-bit wait counter SHALL load MEM_WAIT; otherwise it SHALL load 0.
REQ-015 mem_stall SHALL equal E1.valid & (cnt!=0); cnt SHALL decrement while non-zero. A memory op therefore occupies MEM for MEM_WAIT+1 cycles.
REQ-016 stall_cycles SHALL increment on every cycle in which freeze=1 or mem_stall=1, and saturate at all-ones.
REQ-017 A branch_taken held during mem_stall SHALL take effect on the first cycle after mem_stall falls.

Reset
REQ-018 rst=0 SHALL asynchronously clear all entries to invalid, cnt=0, fwd_sel_a=fwd_sel_b=00 and stall_cycles=0.
REQ-019 In reset, freeze, bubble, flush and mem_stall SHALL be 0.
REQ-020 Reset asserted mid-stall SHALL abort the stall; there SHALL be no pending state after release.

Structure
REQ-021 The entry record type, the fwd_sel encodings (FWD_REG, FWD_MEM, FWD_WB) and the default parameters SHALL live in the shared pipeline package.
REQ-022 A single sub-module, hazard_cmp, SHALL compute source-vs-entry match for one source. It SHALL be instantiated per source.

Verification
REQ-023 FWD_EN=1, ADD r3 then SUB r4,r3,r1 back-to-back -> no freeze; fwd_sel_a=01 while SUB is in EXE.
REQ-024 FWD_EN=1, LDR r2 then ADD r5,r2,r2 -> one cycle with freeze=bubble=1; then fwd_sel_a=fwd_sel_b=10; stall_cycles=1.
REQ-025 FWD_EN=0, ADD r3 then ORR r6,r3,r0 -> freeze for 2 cycles; ORR then enters EXE with fwd_sel=00.
REQ-026 MEM_WAIT=3, STR then two ALU ops -> mem_stall=1 for exactly 3 cycles; entries hold; stall_cycles=3.
REQ-027 Hazard and branch_taken in the same cycle -> flush=1, freeze=0, E0 invalid next cycle.
REQ-028 rst=0 pulsed during the second cycle of a MEM_WAIT=3 stall -> all outputs 0 immediately; after release, the first new load stalls 3 cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline types, fwd_sel encodings and default parameters
package pipe_hazard_ctrl_pkg;
   localparam int RA_W_DEF     = 4;
   localparam int FWD_EN_DEF   = 1;
   localparam int MEM_WAIT_DEF = 0;
   localparam int PERF_W_DEF   = 16;
   // entry dest field is sized for the widest supported register index (RA_W <= RA_MAX)
   localparam int RA_MAX = 8;
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   typedef struct packed {
      logic              valid;
      logic [RA_MAX-1:0] dest;
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
   } entry_t;
   // youngest producer wins: EXE result (now heading to MEM) beats MEM result (heading to WB)
   function automatic logic [1:0] fwd_pick(input logic en, input logic [2:0] m);
      return !en ? FWD_REG : m[0] ? FWD_MEM : m[1] ? FWD_WB : FWD_REG;
   endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: match one ID source register against the three in-flight entries
//   src   : source register index
//   used  : source is actually read
//   ent   : in-flight entries E0 (EXE), E1 (MEM), E2 (WB)
//   match : bit k set when entry k will write src
module hazard_cmp import pipe_hazard_ctrl_pkg::*; #(
   parameter int RA_W = RA_W_DEF
) (
   input  logic [RA_W-1:0] src,
   input  logic            used,
   input  entry_t          ent [3],
   output logic [2:0]      match
);
   for (genvar k = 0; k < 3; k++) begin : g_m
      assign match[k] = used & ent[k].valid & ent[k].wb_en & (ent[k].dest == RA_MAX'(src));
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW/load-use hazard detection, forwarding select, branch flush and MEM wait stall
//   clk, rst (async active-low)
//   id_* : instruction currently in ID; branch_taken : EXE resolved a taken branch
//   freeze/bubble : hold PC+IF/ID and insert NOP into ID/EXE
//   flush : squash IF/ID; mem_stall : hold every pipeline register
//   fwd_sel_a/b : EXE operand source; stall_cycles : saturating freeze/stall counter
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
   parameter int RA_W     = RA_W_DEF,
   parameter int FWD_EN   = FWD_EN_DEF,
   parameter int MEM_WAIT = MEM_WAIT_DEF,
   parameter int PERF_W   = PERF_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [RA_W-1:0]   id_src1,
   input  logic [RA_W-1:0]   id_src2,
   input  logic              id_src1_used,
   input  logic              id_src2_used,
   input  logic [RA_W-1:0]   id_dest,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic              id_mem_w_en,
   input  logic              branch_taken,
   output logic              freeze,
   output logic              bubble,
   output logic              flush,
   output logic              mem_stall,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic [PERF_W-1:0] stall_cycles
);
   entry_t     ent [3];
   entry_t     id_ent;
   logic [3:0] cnt;
   logic [2:0] m_a, m_b;
   logic       hazard, adv_in;
   hazard_cmp #(.RA_W(RA_W)) u_cmp_a (.src(id_src1), .used(id_src1_used), .ent(ent), .match(m_a));
   hazard_cmp #(.RA_W(RA_W)) u_cmp_b (.src(id_src2), .used(id_src2_used), .ent(ent), .match(m_b));
   // with forwarding only a load still in EXE is unresolvable; without it, E0 and E1 both block
   // (E2 is covered by write-before-read in the register file)
   always_comb begin
      id_ent    = '{valid: 1'b1, dest: RA_MAX'(id_dest), wb_en: id_wb_en,
                    mem_r_en: id_mem_r_en, mem_w_en: id_mem_w_en};
      mem_stall = ent[1].valid & (cnt != 4'd0);
      hazard    = (FWD_EN != 0) ? |((m_a | m_b) & {2'b00, ent[0].mem_r_en})
                                : |((m_a | m_b) & 3'b011);
      flush     = rst & branch_taken & ~mem_stall;
      freeze    = rst & hazard & id_valid & ~branch_taken & ~mem_stall;
      bubble    = freeze;
      adv_in    = id_valid & ~freeze & ~flush;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent          <= '{default: '0};
         cnt          <= 4'd0;
         fwd_sel_a    <= FWD_REG;
         fwd_sel_b    <= FWD_REG;
         stall_cycles <= '0;
      end else begin
         if ((freeze | mem_stall) & ~&stall_cycles)
            stall_cycles <= stall_cycles + PERF_W'(1);
         if (mem_stall)
            cnt <= cnt - 4'd1;
         else begin
            ent[2]    <= ent[1];
            ent[1]    <= ent[0];
            ent[0]    <= adv_in ? id_ent : '0;
            cnt       <= (ent[0].valid & (ent[0].mem_r_en | ent[0].mem_w_en)) ? 4'(MEM_WAIT) : 4'd0;
            fwd_sel_a <= fwd_pick((FWD_EN != 0) & adv_in, m_a);
            fwd_sel_b <= fwd_pick((FWD_EN != 0) & adv_in, m_b);
         end
      end
   end
endmodule
